// File: rtl/can_tx_frame_serializer_if.sv
// Host-side request/status bundle for the CAN transmit frame serializer.
`timescale 1ns/1ps
interface can_tx_frame_serializer_if;
  logic        start;
  logic        ide;
  logic        rtr;
  logic [28:0] id;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        busy;
  logic        done;
  logic        arb_lost;
  logic        ack_err;
  logic [7:0]  frame_bits;

  modport master (
    output start, ide, rtr, id, dlc, data,
    input  busy, done, arb_lost, ack_err, frame_bits
  );

  modport slave (
    input  start, ide, rtr, id, dlc, data,
    output busy, done, arb_lost, ack_err, frame_bits
  );
endinterface

// File: rtl/can_tx_frame_serializer.sv
// Serializes one CAN 2.0A/2.0B frame onto tx with CRC-15, bit stuffing,
// arbitration-loss detection and ACK-slot checking.
//
// state    | meaning
// IDLE     | line recessive, waiting for start
// SOF      | start-of-frame dominant bit
// ARB      | identifier (+SRR/IDE for extended) and RTR
// CTRL     | IDE/r1, r0, DLC
// DATA     | payload bits, MSB of byte 0 first
// CRC      | 15-bit CRC sequence
// CRC_DEL  | CRC delimiter
// ACK      | ACK slot, rx sampled for a dominant acknowledge
// ACK_DEL  | ACK delimiter
// EOF      | 7 recessive bits
// IFS      | 3 recessive intermission bits
`timescale 1ns/1ps
module can_tx_frame_serializer #(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 1000,
  parameter int SAMPLE_PT          = 75
) (
  input  logic                        clk,
  input  logic                        rst_n,
  can_tx_frame_serializer_if.slave    host,
  input  logic                        rx,
  output logic                        tx
);
  localparam int BIT_CLKS = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
  localparam int BW = $clog2(BIT_CLKS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] SMP      = BW'(SAMPLE_PT);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SOF     = 4'd1;
  localparam logic [3:0] S_ARB     = 4'd2;
  localparam logic [3:0] S_CTRL    = 4'd3;
  localparam logic [3:0] S_DATA    = 4'd4;
  localparam logic [3:0] S_CRC     = 4'd5;
  localparam logic [3:0] S_CRC_DEL = 4'd6;
  localparam logic [3:0] S_ACK     = 4'd7;
  localparam logic [3:0] S_ACK_DEL = 4'd8;
  localparam logic [3:0] S_EOF     = 4'd9;
  localparam logic [3:0] S_IFS     = 4'd10;

  logic [3:0]    state, adv_state;
  logic [6:0]    fld_cnt, adv_cnt;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    run_len;
  logic          stuff_now;
  logic [14:0]   crc, crc_upd, crc_nxt;
  logic          ide_q;
  logic [31:0]   arb_q;
  logic [3:0]    dlc_q;
  logic [63:0]   data_q;
  logic [6:0]    data_len_q;
  logic [5:0]    ctrl_bits;
  logic          tx_q, busy_q, done_q, arb_lost_q, ack_err_q;
  logic [7:0]    frame_bits_q;
  logic          bit_end, in_crc_region, need_stuff, nxt_bit;

  assign tx              = tx_q;
  assign host.busy       = busy_q;
  assign host.done       = done_q;
  assign host.arb_lost   = arb_lost_q;
  assign host.ack_err    = ack_err_q;
  assign host.frame_bits = frame_bits_q;

  always_comb begin
    bit_end       = (bit_cnt == BIT_LAST);
    in_crc_region = state inside {S_SOF, S_ARB, S_CTRL, S_DATA};
    crc_upd       = {crc[13:0], 1'b0} ^ ((tx_q ^ crc[14]) ? 15'h4599 : 15'h0000);
    crc_nxt       = (!stuff_now && in_crc_region) ? crc_upd : crc;
    // A stuff bit does not advance the field position; state/fld_cnt still name
    // the last unstuffed bit while it is on the line.
    need_stuff    = (in_crc_region || state == S_CRC) && !stuff_now && (run_len == 3'd5);
    ctrl_bits     = {2'b00, dlc_q};

    adv_state = state;
    adv_cnt   = fld_cnt + 7'd1;
    case (state)
      S_SOF: begin
        adv_state = S_ARB;
        adv_cnt   = 7'd0;
      end
      S_ARB:
        if (fld_cnt == (ide_q ? 7'd31 : 7'd11)) begin
          adv_state = S_CTRL;
          adv_cnt   = 7'd0;
        end
      S_CTRL:
        if (fld_cnt == 7'd5) begin
          adv_state = (data_len_q == 7'd0) ? S_CRC : S_DATA;
          adv_cnt   = 7'd0;
        end
      S_DATA:
        if (fld_cnt == data_len_q - 7'd1) begin
          adv_state = S_CRC;
          adv_cnt   = 7'd0;
        end
      S_CRC:
        if (fld_cnt == 7'd14) begin
          adv_state = S_CRC_DEL;
          adv_cnt   = 7'd0;
        end
      S_CRC_DEL: begin
        adv_state = S_ACK;
        adv_cnt   = 7'd0;
      end
      S_ACK: begin
        adv_state = S_ACK_DEL;
        adv_cnt   = 7'd0;
      end
      S_ACK_DEL: begin
        adv_state = S_EOF;
        adv_cnt   = 7'd0;
      end
      S_EOF:
        if (fld_cnt == 7'd6) begin
          adv_state = S_IFS;
          adv_cnt   = 7'd0;
        end
      S_IFS:
        if (fld_cnt == 7'd2) begin
          adv_state = S_IDLE;
          adv_cnt   = 7'd0;
        end
      default: begin
        adv_state = S_IDLE;
        adv_cnt   = 7'd0;
      end
    endcase

    case (adv_state)
      S_ARB:   nxt_bit = arb_q[5'd31 - adv_cnt[4:0]];
      S_CTRL:  nxt_bit = ctrl_bits[3'd5 - adv_cnt[2:0]];
      S_DATA:  nxt_bit = data_q[6'd63 - adv_cnt[5:0]];
      S_CRC:   nxt_bit = crc_nxt[4'd14 - adv_cnt[3:0]];
      default: nxt_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      fld_cnt      <= 7'd0;
      bit_cnt      <= '0;
      run_len      <= 3'd0;
      stuff_now    <= 1'b0;
      crc          <= 15'd0;
      ide_q        <= 1'b0;
      arb_q        <= 32'd0;
      dlc_q        <= 4'd0;
      data_q       <= 64'd0;
      data_len_q   <= 7'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      arb_lost_q   <= 1'b0;
      ack_err_q    <= 1'b0;
      frame_bits_q <= 8'd0;
    end else begin
      done_q     <= 1'b0;
      arb_lost_q <= 1'b0;
      ack_err_q  <= 1'b0;
      if (state == S_IDLE) begin
        // done_q blocks a request landing in the completion cycle
        if (host.start && !done_q) begin
          ide_q        <= host.ide;
          arb_q        <= host.ide ? {host.id[28:18], 2'b11, host.id[17:0], host.rtr}
                                   : {host.id[10:0], host.rtr, 20'd0};
          dlc_q        <= host.dlc;
          data_q       <= host.data;
          data_len_q   <= host.rtr ? 7'd0 : ((host.dlc > 4'd8) ? 7'd64 : {host.dlc, 3'b000});
          state        <= S_SOF;
          fld_cnt      <= 7'd0;
          bit_cnt      <= '0;
          run_len      <= 3'd1;
          stuff_now    <= 1'b0;
          crc          <= 15'd0;
          tx_q         <= 1'b0;
          busy_q       <= 1'b1;
          frame_bits_q <= 8'd0;
        end
      end else if (bit_cnt == SMP && state == S_ARB && tx_q && !rx) begin
        arb_lost_q <= 1'b1;
        tx_q       <= 1'b1;
        busy_q     <= 1'b0;
        state      <= S_IDLE;
        bit_cnt    <= '0;
      end else begin
        if (bit_cnt == SMP && state == S_ACK && rx)
          ack_err_q <= 1'b1;
        if (!bit_end) begin
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          bit_cnt <= '0;
          crc     <= crc_nxt;
          if (!stuff_now)
            frame_bits_q <= frame_bits_q + 8'd1;
          if (need_stuff) begin
            tx_q      <= ~tx_q;
            stuff_now <= 1'b1;
            run_len   <= 3'd1;
          end else if (adv_state == S_IDLE) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            tx_q   <= 1'b1;
          end else begin
            state     <= adv_state;
            fld_cnt   <= adv_cnt;
            tx_q      <= nxt_bit;
            stuff_now <= 1'b0;
            if (nxt_bit != tx_q)
              run_len <= 3'd1;
            else if (run_len != 3'd7)
              run_len <= run_len + 3'd1;
          end
        end
      end
    end
  end
endmodule
